// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enc_pkg
// Brief    : Shared constants and helpers for the request-encoder family.
// Revision : 1.0 - initial release
// ============================================================================
package enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Widest request vector the shared helper accepts; callers zero-extend.
    localparam int ENC_MAX_N = 256;

    // True when more than one bit is set: clearing the lowest set bit leaves
    // something behind only for multi-hot vectors.
    function automatic logic multi_hot(input logic [ENC_MAX_N-1:0] v);
        return |(v & (v - ENC_MAX_N'(1)));
    endfunction

endpackage : enc_pkg
`default_nettype wire

// File: rtl/enc_prio_core.sv
`default_nettype none
// ============================================================================
// Module   : enc_prio_core
// Brief    : Combinational lowest-set-bit encoder with an any-set flag.
// Revision : 1.0 - initial release
// ============================================================================
module enc_prio_core #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan downwards so the lowest set bit is the last one to win.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule : enc_prio_core
`default_nettype wire

// File: rtl/enc_prio_rr.sv
`default_nettype none
// ============================================================================
// Module   : enc_prio_rr
// Brief    : N-to-log2(N) request encoder, fixed-priority or round-robin,
//            with a registered valid/ready output and multi/empty flags.
//            Define ENC_ERR_STICKY_EN to make err sticky until reset.
// Revision : 1.0 - initial release
// ============================================================================
module enc_prio_rr
    import enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] y,
    output logic         multi,
    output logic         none,
    output logic         err
);

    logic         r_valid;
    logic [W-1:0] r_y;
    logic         r_multi;
    logic         r_none;
    logic         r_err;
    logic [W-1:0] r_ptr;

    logic [N-1:0] w_mask;
    logic [N-1:0] w_masked;
    logic [W-1:0] w_raw_idx;
    logic         w_raw_any;
    logic [W-1:0] w_msk_idx;
    logic         w_msk_any;
    logic [W-1:0] w_grant;
    logic [W-1:0] w_ptr_next;
    logic         w_multi;
    logic         w_cap;

    // Requests at or above the pointer get first claim in round-robin mode.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (W'(i) >= r_ptr);
        end
    end

    assign w_masked = req & w_mask;

    enc_prio_core #(.N(N), .W(W)) u_core_raw (
        .vec (req),
        .idx (w_raw_idx),
        .any (w_raw_any)
    );

    enc_prio_core #(.N(N), .W(W)) u_core_msk (
        .vec (w_masked),
        .idx (w_msk_idx),
        .any (w_msk_any)
    );

    assign w_grant    = (mode == MODE_RR && w_msk_any) ? w_msk_idx : w_raw_idx;
    assign w_ptr_next = (w_grant == W'(N - 1)) ? '0 : w_grant + W'(1);
    assign w_multi    = multi_hot(ENC_MAX_N'(req));
    assign w_cap      = en & w_raw_any & (~r_valid | out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_y     <= '0;
            r_multi <= 1'b0;
            r_none  <= 1'b0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_none <= en & ~w_raw_any;
            if (w_cap) begin
                r_y     <= w_grant;
                r_multi <= w_multi;
                r_valid <= 1'b1;
                if (mode == MODE_RR) begin
                    r_ptr <= w_ptr_next;
                end
`ifdef ENC_ERR_STICKY_EN
                if (w_multi) begin
                    r_err <= 1'b1;
                end
`else
                r_err <= w_multi;
`endif
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
`ifndef ENC_ERR_STICKY_EN
                r_err   <= 1'b0;
`endif
            end
        end
    end

    assign out_valid = r_valid;
    assign y         = r_y;
    assign multi     = r_multi;
    assign none      = r_none;
    assign err       = r_err;

endmodule : enc_prio_rr
`default_nettype wire

// File: tb/tb_enc_prio_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_prio_rr
// Brief    : Self-checking bench for enc_prio_rr against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc_prio_rr;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] y;
    logic         multi;
    logic         none;
    logic         err;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    enc_prio_rr #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .mode      (mode),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .y         (y),
        .multi     (multi),
        .none      (none),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural model: rotating search starting at the pointer.
    int m_ptr = 0;
    int m_y = 0;
    bit m_valid = 0, m_multi = 0, m_none = 0, m_err = 0;
    bit m_cap;
    int m_grant;

    function automatic int model_grant(input logic [N-1:0] r, input bit rr, input int p);
        int start;
        start = rr ? p : 0;
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    always_comb begin
        m_cap   = 1'b0;
        m_grant = 0;
        m_cap   = en && (req != '0) && (!m_valid || out_ready);
        m_grant = model_grant(req, mode, m_ptr);
    end

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 0; m_y <= 0; m_multi <= 0; m_none <= 0; m_err <= 0; m_ptr <= 0;
        end else begin
            m_none <= en && (req == '0);
            if (m_cap) begin
                m_y     <= m_grant;
                m_multi <= ($countones(req) > 1);
                m_valid <= 1;
                if (mode) m_ptr <= (m_grant + 1) % N;
`ifdef ENC_ERR_STICKY_EN
                if ($countones(req) > 1) m_err <= 1;
`else
                m_err <= ($countones(req) > 1);
`endif
            end else if (m_valid && out_ready) begin
                m_valid <= 0;
`ifndef ENC_ERR_STICKY_EN
                m_err   <= 0;
`endif
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (out_valid !== m_valid || none !== m_none || err !== m_err ||
                int'(y) != m_y || y === 'x || multi !== m_multi) begin
                fails++;
                $display("FAIL model t=%0t: got v=%0b y=%0d m=%0b n=%0b e=%0b, want v=%0b y=%0d m=%0b n=%0b e=%0b",
                         $time, out_valid, y, multi, none, err, m_valid, m_y, m_multi, m_none, m_err);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = '0; mode = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", int'(out_valid), 0);
        check("rst_y",     int'(y),         0);
        check("rst_multi", int'(multi),     0);
        check("rst_none",  int'(none),      0);
        check("rst_err",   int'(err),       0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Fixed priority, single and multi-hot.
        en = 1'b1; req = 8'b0000_0100;
        tick();
        check("fix_valid", int'(out_valid), 1);
        check("fix_y",     int'(y),         2);
        check("fix_multi", int'(multi),     0);
        check("fix_err",   int'(err),       0);
        req = 8'b1001_0000;
        tick();
        check("fix_multi_y",   int'(y),     4);
        check("fix_multi_m",   int'(multi), 1);
        check("fix_multi_err", int'(err),   1);
        req = 8'h01;
        tick();
        check("fix_after_y", int'(y), 0);
`ifdef ENC_ERR_STICKY_EN
        check("err_sticky", int'(err), 1);
`else
        check("err_drops", int'(err), 0);
`endif

        // Round-robin sweep with all requests asserted.
        mode = 1'b1; req = 8'hFF;
        for (int k = 0; k <= N; k++) begin
            tick();
            check("rr_sweep_y", int'(y), k % N);
        end
        tick();
        check("rr_to_ptr2", int'(y), 1);
        req = 8'b0000_0011;
        tick();
        check("rr_wrap_y", int'(y), 0);
        tick();
        check("rr_next_y", int'(y), 1);

        // Backpressure holds the output.
        mode = 1'b0; req = 8'h08;
        tick();
        check("bp_cap_y", int'(y), 3);
        out_ready = 1'b0; req = 8'h20;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_hold_y", int'(y),         3);
            check("bp_hold_v", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_y", int'(y), 5);

        // Enable low and empty request.
        en = 1'b0; req = 8'h01;
        tick();
        tick();
        check("en_low_valid", int'(out_valid), 0);
        en = 1'b1; req = '0;
        tick();
        check("none_set",   int'(none),      1);
        check("none_valid", int'(out_valid), 0);

        // Drive ptr to 5, then reset mid-stream.
        mode = 1'b1; req = 8'h04;
        tick();
        req = 8'h10;
        tick();
        check("ptr5_y", int'(y), 4);
        rst = 1'b1; req = 8'hFF;
        tick();
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_y",     int'(y),         0);
        check("mid_rst_multi", int'(multi),     0);
        check("mid_rst_err",   int'(err),       0);
        rst = 1'b0;
        tick();
        check("post_rst_y", int'(y), 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            en        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            case ($urandom_range(0, 3))
                0:       req = N'(1) << $urandom_range(0, N - 1);
                1:       req = '0;
                default: req = N'($urandom);
            endcase
            tick();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_enc_prio_rr
`default_nettype wire
